// File: rtl/cpu_reg_slave.sv
// cpu_reg_slave: CPU register slave with programmable wait states.
//
// Optional feature macro: CPU_REG_SLAVE_LOCK_EN. When it is defined,
// CONTROL[31]=1 write-protects SCRATCH and DATA0..DATA3.
//
// Register map (word address):
//   0 ID (RO)      1 CONTROL (RW)     2 STATUS (RO)     3 SCRATCH (RW)
//   4..7 DATA0..DATA3 (RW)            >= 8 unmapped
//
// Ports:
//   clk_i              clock, rising edge
//   reset_i            synchronous active-high reset
//   timeout_i          master abort of the access waiting in WAIT
//   read_i / write_i   strobes, held by the master until access_complete_o
//   write_data_i       write data
//   address_i          word address (byte address bits [31:2])
//   read_data_o        read data, non-zero only during access_complete_o
//   access_complete_o  one-cycle response pulse
//   invalid_address_o  address outside the map (qualified by access_complete_o)
//   invalid_access_o   illegal operation (qualified by access_complete_o)
module cpu_reg_slave #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        timeout_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] write_data_i,
    input  logic [29:0] address_i,
    output logic [31:0] read_data_o,
    output logic        access_complete_o,
    output logic        invalid_address_o,
    output logic        invalid_access_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [29:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              is_wr_q;
    logic              is_err_q;   // read and write sampled together
    logic [31:0]       ctrl_q, scratch_q;
    logic [3:0][31:0]  data_q;
    logic [15:0]       wr_cnt_q, err_cnt_q;

    logic              capture;
    logic              commit;     // valid write takes effect this cycle
    logic              flag_resp;  // response carrying an error flag

    // Decode of the captured access
    logic [2:0]  idx;
    logic        mapped, ro_tgt, locked, bad_addr, bad_access, wr_ok;
    logic [31:0] rd_val;

    assign idx    = addr_q[2:0];
    assign mapped = (addr_q[29:3] == '0);
    assign ro_tgt = (idx == 3'd0) || (idx == 3'd2);

`ifdef CPU_REG_SLAVE_LOCK_EN
    assign locked = ctrl_q[31] && ((idx == 3'd3) || idx[2]);
`else
    assign locked = 1'b0;
`endif

    // A double strobe is reported as an access error regardless of address.
    assign bad_access = is_err_q || (mapped && is_wr_q && (ro_tgt || locked));
    assign bad_addr   = !is_err_q && !mapped;
    assign wr_ok      = is_wr_q && !bad_access && !bad_addr;

    always_comb begin
        rd_val = '0;
        case (idx)
            3'd0:    rd_val = ID_VALUE;
            3'd1:    rd_val = ctrl_q;
            3'd2:    rd_val = {err_cnt_q, wr_cnt_q};
            3'd3:    rd_val = scratch_q;
            default: rd_val = data_q[idx[1:0]];
        endcase
    end

    // FSM next state and outputs
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        capture           = 1'b0;
        commit            = 1'b0;
        flag_resp         = 1'b0;
        read_data_o       = '0;
        access_complete_o = 1'b0;
        invalid_address_o = 1'b0;
        invalid_access_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read_i || write_i) begin
                    capture = 1'b1;
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (timeout_i) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                access_complete_o = 1'b1;
                invalid_address_o = bad_addr;
                invalid_access_o  = bad_access;
                if (!is_wr_q && !bad_addr && !bad_access)
                    read_data_o = rd_val;
                commit    = wr_ok;
                flag_resp = bad_addr || bad_access;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (!read_i && !write_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            is_err_q  <= 1'b0;
            ctrl_q    <= '0;
            scratch_q <= '0;
            data_q    <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (capture) begin
                addr_q   <= address_i;
                wdata_q  <= write_data_i;
                is_wr_q  <= write_i;
                is_err_q <= read_i && write_i;
            end
            if (commit) begin
                case (idx)
                    3'd1:    ctrl_q    <= wdata_q;
                    3'd3:    scratch_q <= wdata_q;
                    3'd4, 3'd5, 3'd6, 3'd7: data_q[idx[1:0]] <= wdata_q;
                    default: ;
                endcase
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (flag_resp)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_cpu_reg_slave.sv
module tb_cpu_reg_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, timeout, read, write, sel;
    logic [31:0] wdata;
    logic [29:0] addr;

    logic [31:0] rd1, rd3;
    logic        ac1, ac3, ia1, ia3, iacc1, iacc3;

    // sel=0 routes the strobes to the WAIT_STATES=1 slave, sel=1 to the WAIT_STATES=3 slave
    cpu_reg_slave #(.WAIT_STATES(1)) dut (
        .clk_i(clk), .reset_i(reset), .timeout_i(timeout & ~sel),
        .read_i(read & ~sel), .write_i(write & ~sel),
        .write_data_i(wdata), .address_i(addr),
        .read_data_o(rd1), .access_complete_o(ac1),
        .invalid_address_o(ia1), .invalid_access_o(iacc1)
    );

    cpu_reg_slave #(.WAIT_STATES(3)) dut3 (
        .clk_i(clk), .reset_i(reset), .timeout_i(timeout & sel),
        .read_i(read & sel), .write_i(write & sel),
        .write_data_i(wdata), .address_i(addr),
        .read_data_o(rd3), .access_complete_o(ac3),
        .invalid_address_o(ia3), .invalid_access_o(iacc3)
    );

    logic [31:0] rd_m;
    logic        ac_m, ia_m, iacc_m;
    assign rd_m   = sel ? rd3   : rd1;
    assign ac_m   = sel ? ac3   : ac1;
    assign ia_m   = sel ? ia3   : ia1;
    assign iacc_m = sel ? iacc3 : iacc1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        ia;
        logic        iacc;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        sel;
        logic        rd;
        logic        wr;
        logic [29:0] a;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eia;
        logic        eiacc;
    } vec_t;
    vec_t tbl[$];

    // Response monitor: every pulse must match the oldest expectation,
    // and outputs must be quiet whenever there is no pulse.
    always @(negedge clk) begin
        exp_t e;
        if (ac_m) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_response cyc=%0d rd=%h ia=%b iacc=%b", cyc, rd_m, ia_m, iacc_m);
            end else begin
                e = sb.pop_front();
                if (rd_m !== e.rd || ia_m !== e.ia || iacc_m !== e.iacc || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL response got rd=%h ia=%b iacc=%b cyc=%0d want rd=%h ia=%b iacc=%b cyc=%0d",
                             rd_m, ia_m, iacc_m, cyc, e.rd, e.ia, e.iacc, e.cyc);
                end
            end
        end else if (!reset) begin
            checks++;
            if (rd_m !== 32'h0 || ia_m !== 1'b0 || iacc_m !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d got rd=%h ia=%b iacc=%b want zeros", cyc, rd_m, ia_m, iacc_m);
            end
        end
    end

    task automatic run(input vec_t v, input int hold);
        exp_t e;
        int   k;
        @(posedge clk); #1;
        sel = v.sel; read = v.rd; write = v.wr; addr = v.a; wdata = v.wd;
        e.rd = v.erd; e.ia = v.eia; e.iacc = v.eiacc;
        e.cyc = cyc + 1 + (v.sel ? 3 : 1);
        sb.push_back(e);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ac_m) break;
        end
        if (k == 40) begin
            checks++; errors++;
            $display("FAIL no_response addr=%0d got none want access_complete", v.a);
            sb.delete();
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic w, input logic [29:0] a,
                                input logic [31:0] wd, input logic [31:0] erd, input logic eia, input logic eiacc);
        vec_t v;
        v.sel = s; v.rd = r; v.wr = w; v.a = a; v.wd = wd;
        v.erd = erd; v.eia = eia; v.eiacc = eiacc;
        return v;
    endfunction

    initial begin
        int seen;
        reset = 1'b1; timeout = 1'b0; read = 1'b0; write = 1'b0;
        sel = 1'b0; wdata = '0; addr = '0;

        tbl.push_back(mk(0, 0, 1, 30'd3, 32'hA5A5_5A5A, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd3, 32'h0, 32'hA5A5_5A5A, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd2, 32'h0, 32'h0000_0001, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd0, 32'h0, 32'hC0DE_0001, 0, 0));
        tbl.push_back(mk(0, 0, 1, 30'd0, 32'h1234_5678, 32'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 30'd2, 32'h0, 32'h0001_0001, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd9, 32'h0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 30'd3, 32'hFFFF_FFFF, 32'h0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 30'd1, 32'h8000_0000, 32'h0, 0, 0));
`ifdef CPU_REG_SLAVE_LOCK_EN
        tbl.push_back(mk(0, 0, 1, 30'd5, 32'h1234_5678, 32'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 30'd5, 32'h0, 32'h0, 0, 0));
`else
        tbl.push_back(mk(0, 0, 1, 30'd5, 32'h1234_5678, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd5, 32'h0, 32'h1234_5678, 0, 0));
`endif
        tbl.push_back(mk(0, 0, 1, 30'd2, 32'h5555_5555, 32'h0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 30'd1, 32'h0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd1, 32'h0, 32'h0, 0, 0));
`ifdef CPU_REG_SLAVE_LOCK_EN
        tbl.push_back(mk(0, 1, 0, 30'd2, 32'h0, 32'h0005_0003, 0, 0));
`else
        tbl.push_back(mk(0, 1, 0, 30'd2, 32'h0, 32'h0004_0004, 0, 0));
`endif
        tbl.push_back(mk(0, 0, 1, 30'd7, 32'hDEAD_BEEF, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd7, 32'h0, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd4, 32'h0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 30'd8, 32'h0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 30'h2000_0003, 32'h1, 32'h0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 30'd3, 32'h0, 32'hA5A5_5A5A, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ac1, ia1, iacc1, ac3, ia3, iacc3} !== 6'b0 || rd1 !== 32'h0 || rd3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ac=%b%b rd=%h/%h want all zero", ac1, ac3, rd1, rd3);
        end
        @(posedge clk); #1 reset = 1'b0;

        foreach (tbl[i]) run(tbl[i], 0);

        // Strobe held 5 extra cycles after the response: monitor flags any second pulse
        run(mk(0, 1, 0, 30'd0, 32'h0, 32'hC0DE_0001, 0, 0), 5);

        // WAIT_STATES=3: a normal write, then a write aborted by timeout in its 2nd WAIT cycle
        run(mk(1, 0, 1, 30'd4, 32'h0BAD_F00D, 32'h0, 0, 0), 0);
        @(posedge clk); #1;
        sel = 1'b1; write = 1'b1; addr = 30'd4; wdata = 32'h5555_AAAA;
        @(posedge clk); #1;          // strobe sampled, first WAIT cycle
        @(posedge clk); #1;          // second WAIT cycle
        timeout = 1'b1;
        @(posedge clk); #1;
        timeout = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ac3) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL timeout_abort got %0d responses want 0", seen);
        end
        @(posedge clk); #1 write = 1'b0;
        run(mk(1, 1, 0, 30'd4, 32'h0, 32'h0BAD_F00D, 0, 0), 0);
        run(mk(1, 1, 0, 30'd2, 32'h0, 32'h0000_0001, 0, 0), 0);

        // Reset asserted while a write sits in WAIT
        @(posedge clk); #1;
        sel = 1'b0; write = 1'b1; addr = 30'd3; wdata = 32'h1111_1111;
        @(posedge clk); #1;          // now in WAIT
        reset = 1'b1;
        @(posedge clk);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ac1 || ia1 || iacc1 || rd1 != 32'h0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_in_wait got %0d non-zero output cycles want 0", seen);
        end
        #1 write = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        run(mk(0, 1, 0, 30'd3, 32'h0, 32'h0, 0, 0), 0);
        run(mk(0, 1, 0, 30'd2, 32'h0, 32'h0, 0, 0), 0);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_reg_slave.md
CPU_REG_SLAVE -- requirements
Module: cpu_reg_slave

Interface
REQ-001 Parameter WAIT_STATES, default 1, range 0..15: number of wait cycles inserted before each response.
REQ-002 Parameter ID_VALUE, default 32'hC0DE_0001: constant returned by the ID register.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 timeout  input  1  master abort of the outstanding access.
REQ-006 read  input  1  read strobe, held by master until access_complete.
REQ-007 write  input  1  write strobe, held by master until access_complete.
REQ-008 write_data  input  32  write data, valid while write is high.
REQ-009 address  input  30  word address, bits [31:2].
REQ-010 read_data  output  32  read data, valid only while access_complete is high; 0 otherwise.
REQ-011 access_complete  output  1  one-cycle response pulse.
REQ-012 invalid_address  output  1  qualified by access_complete; address outside the map.
REQ-013 invalid_access  output  1  qualified by access_complete; illegal operation.

Function
REQ-014 Register map (word address): 0 ID (RO), 1 CONTROL (RW), 2 STATUS (RO), 3 SCRATCH (RW), 4..7 DATA0..DATA3 (RW); address >= 8 is unmapped.
REQ-015 FSM states IDLE, WAIT, RESP, HOLD; reset state IDLE.
REQ-016 IDLE: when read or write is sampled high, capture address, write_data and operation, load the wait counter with WAIT_STATES, and go to WAIT.
REQ-017 WAIT: the counter decrements each cycle; when it reaches 0, go to RESP (WAIT lasts WAIT_STATES cycles; with WAIT_STATES=0, go directly from IDLE to RESP).
REQ-018 Latency: access_complete is high exactly WAIT_STATES+1 cycles after the cycle in which the strobe is first sampled high, for exactly one cycle (RESP).
REQ-019 RESP: drive access_complete=1 with read_data and flags; valid writes update the target register at the end of this cycle; then go to HOLD.
REQ-020 HOLD: remain until read and write are both sampled low, then go to IDLE; no new access is accepted in HOLD.
REQ-021 read and write both high when sampled in IDLE: complete as an error access; invalid_access=1, no register update, read_data=0.
REQ-022 Unmapped address: invalid_address=1, invalid_access=0, no update, read_data=0.
REQ-023 Write to ID or STATUS: invalid_access=1, no update.
REQ-024 Reads of RW registers return their current value; ID returns ID_VALUE.
REQ-025 STATUS[15:0] counts completed valid writes; STATUS[31:16] counts responses with either invalid flag set; both counters wrap from 16'hFFFF to 0.
REQ-026 timeout sampled high in WAIT: abort, go to HOLD, no access_complete, no register or counter update.
REQ-027 timeout in IDLE, RESP or HOLD: ignored.
REQ-028 Strobe changes during WAIT are ignored; the captured operation is used.

Reset
REQ-029 While reset is high, at each rising edge: FSM to IDLE, wait counter to 0, CONTROL/SCRATCH/DATA0..3 to 0, STATUS counters to 0, all outputs to 0.
REQ-030 Reset mid-access (WAIT or RESP): the access is discarded with no register update; outputs are 0 from the first cycle after the reset edge.

Configuration
REQ-031 Macro CPU_REG_SLAVE_LOCK_EN: when defined, CONTROL[31]=1 makes SCRATCH and DATA0..3 write-protected; a write to them returns invalid_access=1 with no update; CONTROL itself stays writable.
REQ-032 Without CPU_REG_SLAVE_LOCK_EN, CONTROL[31] is an ordinary storage bit with no effect.

Verification
REQ-033 WAIT_STATES=1; write 32'hA5A5_5A5A to address 3, then read it back -> each access_complete arrives 2 cycles after the strobe, the read returns 32'hA5A5_5A5A, and STATUS reads 32'h0000_0001.
REQ-034 Read address 0 -> read_data=32'hC0DE_0001; write address 0 -> invalid_access=1, and STATUS[31:16] increments.
REQ-035 Read address 9 -> invalid_address=1, read_data=0; read and write asserted together -> invalid_access=1.
REQ-036 WAIT_STATES=3; assert timeout in the 2nd WAIT cycle of a write to address 4 -> no access_complete, DATA0 unchanged, and the next access works after the strobes are deasserted.
REQ-037 Hold the strobe high for 5 cycles after access_complete -> no second response; assert reset during WAIT -> no update and all outputs 0.
REQ-038 With CPU_REG_SLAVE_LOCK_EN: write 32'h8000_0000 to CONTROL, then write address 5 -> invalid_access=1 and DATA1 unchanged.
